index_counter_2d: RTL and testbench
===================================

Name: index_counter_2d

Overview:
- Parametrised successor to the single up-counter: a two-level (row, col) index generator for matrix traversal in the LCMV datapath (correlation-matrix accumulation, inverse and filter loops).
- Bounds are runtime-programmable and latched at start.
- Provides last-index, row-end and completion flags, so the controlling FSMs do not need comparators of their own.

Parameters:
- ROW_WIDTH, 5, width of the row index and rows_m1 bound
- COL_WIDTH, 5, width of the col index and cols_m1 bound

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- reset_count  in  1  synchronous abort: return to IDLE, indices to 0
- start  in  1  latch bounds and begin traversal (honoured in IDLE only)
- up  in  1  advance one index (honoured in RUN only)
- rows_m1  in  ROW_WIDTH  number of rows minus 1, sampled on start
- cols_m1  in  COL_WIDTH  number of cols minus 1, sampled on start
- row  out  ROW_WIDTH  current row index (registered)
- col  out  COL_WIDTH  current col index (registered)
- valid  out  1  high while in RUN; row/col are meaningful
- row_end  out  1  combinational: valid && col == active col limit
- last  out  1  combinational: valid && row == row limit && row_end
- done  out  1  one-cycle pulse after the final advance

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE
  - row=0, col=0
  - latched bounds=0
  - valid=0, done=0; row_end and last therefore 0
- States: IDLE, RUN. valid is the registered decode of RUN.
- Priority each cycle: reset_count > start > up.
- reset_count=1 (any state): next state IDLE, row=col=0, done=0. No done pulse even mid-traversal.
- IDLE, start=1:
  - latch rows_m1 and cols_m1
  - row=col=0, next state RUN
  - valid=1 from the following cycle
- IDLE: up is ignored.
- RUN: start is ignored (no re-latch, no restart).
- RUN, up=1 (col limit = latched cols_m1):
  - if col < limit: col+1, row held
  - else, if row < rows limit: col=0, row+1
  - else (final index): row=col=0, next state IDLE, done=1 for exactly the next cycle
- RUN, up=0: all state held.
- Latency: one-cycle advance latency; done coincides with valid falling.
- Bounds of 0 are legal:
  - rows_m1=0, cols_m1=0 gives a single index; last=1 immediately in RUN; one up completes.
  - rows_m1=0, cols_m1=k: one row of k+1 entries.
- Maximum bounds (all ones) traverse 2^ROW_WIDTH × 2^COL_WIDTH indices with no overflow. Comparisons are equality-against-limit, never increment-and-carry.
- Input bounds changing during RUN have no effect.
- start and up in the same cycle in IDLE: start wins; the traversal begins at (0,0) and up is not counted.
- Total advances to done = (rows_m1+1)·(cols_m1+1) rectangular.

Optional Feature:
- Macro: INDEX_COUNTER_TRIANGULAR_EN
- Defined:
  - Adds input port tri_mode (1 bit), sampled on start.
  - When latched tri_mode=1, the col limit is the current row instead of cols_m1 (lower triangle incl. diagonal, for symmetric correlation matrices).
  - row_end, last and the wrap rule use this limit.
  - Total advances = (rows_m1+1)(rows_m1+2)/2.
  - cols_m1 is ignored in this mode.
- Not defined: no tri_mode port; rectangular traversal only; behaviour identical to the latched tri_mode=0 case.

Test Plan:
- Reset and start:
  - Hold rst=0 for 3 cycles, then release → row=0, col=0, valid=0, done=0.
  - start with rows_m1=1, cols_m1=2, then up held high → sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - row_end high at col=2; last high only at (1,2).
  - done=1 on the cycle after the 6th advance; valid=0 the same cycle.
- Hold and gaps: in RUN, toggle up 1,0,0,1 → indices advance only on up=1 cycles; all outputs stable when up=0. In IDLE, up=1 leaves row/col at 0.
- Abort: at (1,1) of a 3×3 traversal, assert reset_count for 1 cycle together with up=1 → next cycle IDLE, (0,0), valid=0, no done pulse. Then start re-runs from (0,0).
- Boundaries:
  - rows_m1=0, cols_m1=0 → last=1 in the first RUN cycle; a single up gives done.
  - ROW_WIDTH=COL_WIDTH=2 with bounds 3,3 → exactly 16 advances to done, no wrap glitch.
  - Changing cols_m1 mid-run has no effect.
  - start during RUN is ignored.
- Triangular (macro defined): tri_mode=1, rows_m1=2 → (0,0),(1,0),(1,1),(2,0),(2,1),(2,2); row_end at each diagonal; done after 6 advances. With tri_mode=0 the same bench gives rectangular results.

Source files
------------

// File: rtl/index_counter_2d_if.sv
// Control/status bundle for index_counter_2d: the controlling FSM is the master, the counter the slave.
// INDEX_COUNTER_TRIANGULAR_EN adds the tri_mode request bit.
interface index_counter_2d_if #(
  parameter int ROW_WIDTH = 5,
  parameter int COL_WIDTH = 5
);
  logic                 reset_count;
  logic                 start;
  logic                 up;
  logic [ROW_WIDTH-1:0] rows_m1;
  logic [COL_WIDTH-1:0] cols_m1;
`ifdef INDEX_COUNTER_TRIANGULAR_EN
  logic                 tri_mode;
`endif
  logic [ROW_WIDTH-1:0] row;
  logic [COL_WIDTH-1:0] col;
  logic                 valid;
  logic                 row_end;
  logic                 last;
  logic                 done;

  modport master (
`ifdef INDEX_COUNTER_TRIANGULAR_EN
    output tri_mode,
`endif
    output reset_count, start, up, rows_m1, cols_m1,
    input  row, col, valid, row_end, last, done
  );

  modport slave (
`ifdef INDEX_COUNTER_TRIANGULAR_EN
    input  tri_mode,
`endif
    input  reset_count, start, up, rows_m1, cols_m1,
    output row, col, valid, row_end, last, done
  );
endinterface

// File: rtl/index_counter_2d.sv
// Two-level (row, col) index generator with bounds latched at start, row-end/last/done flags.
// INDEX_COUNTER_TRIANGULAR_EN enables lower-triangle traversal selected by tri_mode.
module index_counter_2d #(
  parameter int ROW_WIDTH = 5,
  parameter int COL_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  index_counter_2d_if.slave  bus
);
  localparam int LW = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [COL_WIDTH-1:0] col_q, col_d;
  logic [ROW_WIDTH-1:0] rows_lim_q, rows_lim_d;
  logic [COL_WIDTH-1:0] cols_lim_q, cols_lim_d;
  logic                 done_q, done_d;
  logic [LW-1:0]        col_lim;
  logic                 col_at_lim;
  logic                 row_at_lim;
`ifdef INDEX_COUNTER_TRIANGULAR_EN
  logic                 tri_q, tri_d;

  // In triangular mode the diagonal (current row) bounds each row.
  assign col_lim = tri_q ? LW'(row_q) : LW'(cols_lim_q);
`else
  assign col_lim = LW'(cols_lim_q);
`endif

  assign col_at_lim = (LW'(col_q) == col_lim);
  assign row_at_lim = (row_q == rows_lim_q);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    rows_lim_d = rows_lim_q;
    cols_lim_d = cols_lim_q;
    done_d     = 1'b0;
`ifdef INDEX_COUNTER_TRIANGULAR_EN
    tri_d      = tri_q;
`endif
    if (bus.reset_count) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            rows_lim_d = bus.rows_m1;
            cols_lim_d = bus.cols_m1;
`ifdef INDEX_COUNTER_TRIANGULAR_EN
            tri_d      = bus.tri_mode;
`endif
            row_d      = '0;
            col_d      = '0;
            state_d    = RUN;
          end
        end
        RUN: begin
          if (bus.up) begin
            // Equality-against-limit so all-ones bounds never overflow.
            if (!col_at_lim) begin
              col_d = col_q + COL_WIDTH'(1);
            end else if (!row_at_lim) begin
              col_d = '0;
              row_d = row_q + ROW_WIDTH'(1);
            end else begin
              col_d   = '0;
              row_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      rows_lim_q <= '0;
      cols_lim_q <= '0;
      done_q     <= 1'b0;
`ifdef INDEX_COUNTER_TRIANGULAR_EN
      tri_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rows_lim_q <= rows_lim_d;
      cols_lim_q <= cols_lim_d;
      done_q     <= done_d;
`ifdef INDEX_COUNTER_TRIANGULAR_EN
      tri_q      <= tri_d;
`endif
    end
  end

  assign bus.row     = row_q;
  assign bus.col     = col_q;
  assign bus.valid   = (state_q == RUN);
  assign bus.row_end = bus.valid && col_at_lim;
  assign bus.last    = bus.row_end && row_at_lim;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_index_counter_2d.sv
// Randomized + directed bench for index_counter_2d against a queue-based traversal model.
// Works with or without INDEX_COUNTER_TRIANGULAR_EN.
module tb_index_counter_2d;
  localparam int RW = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  index_counter_2d_if #(.ROW_WIDTH(RW), .COL_WIDTH(CW)) bus ();
  index_counter_2d #(.ROW_WIDTH(RW), .COL_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Model: the full expected index list of the current traversal plus a cursor.
  bit m_run  = 1'b0;
  bit m_done = 1'b0;
  int m_idx  = 0;
  int q_r[$];
  int q_c[$];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void build_seq(input int rows, input int cols, input bit tm);
    q_r.delete();
    q_c.delete();
    for (int r = 0; r <= rows; r++)
      for (int c = 0; c <= (tm ? r : cols); c++) begin
        q_r.push_back(r);
        q_c.push_back(c);
      end
  endfunction

  function automatic void model_reset();
    m_run  = 1'b0;
    m_done = 1'b0;
    m_idx  = 0;
  endfunction

  task automatic compare_all();
    int  er, ec;
    bit  eend, elast;
    er    = m_run ? q_r[m_idx] : 0;
    ec    = m_run ? q_c[m_idx] : 0;
    elast = m_run && (m_idx == q_r.size() - 1);
    eend  = m_run && (elast || q_r[m_idx + 1] != q_r[m_idx]);
    check("valid",   32'(bus.valid),   32'(m_run));
    check("done",    32'(bus.done),    32'(m_done));
    check("row",     32'(bus.row),     er);
    check("col",     32'(bus.col),     ec);
    check("row_end", 32'(bus.row_end), 32'(eend));
    check("last",    32'(bus.last),    32'(elast));
  endtask

  task automatic step(input bit rc, input bit st, input bit u,
                      input int rows, input int cols, input bit tm);
    bit tm_eff;
    bus.reset_count = rc;
    bus.start       = st;
    bus.up          = u;
    bus.rows_m1     = RW'(rows);
    bus.cols_m1     = CW'(cols);
`ifdef INDEX_COUNTER_TRIANGULAR_EN
    bus.tri_mode    = tm;
    tm_eff          = tm;
`else
    tm_eff          = 1'b0;
`endif
    m_done = 1'b0;
    if (rc) begin
      m_run = 1'b0;
      m_idx = 0;
    end else if (!m_run) begin
      if (st) begin
        build_seq(rows, cols, tm_eff);
        m_run = 1'b1;
        m_idx = 0;
      end
    end else if (u) begin
      if (m_idx == q_r.size() - 1) begin
        m_run  = 1'b0;
        m_idx  = 0;
        m_done = 1'b1;
      end else begin
        m_idx++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int cnt;
    rst             = 1'b0;
    bus.reset_count = 1'b0;
    bus.start       = 1'b0;
    bus.up          = 1'b0;
    bus.rows_m1     = '0;
    bus.cols_m1     = '0;
`ifdef INDEX_COUNTER_TRIANGULAR_EN
    bus.tri_mode    = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b1;
    @(negedge clk);
    compare_all();

    // 2x3 rectangular traversal with up held high
    step(0, 1, 0, 1, 2, 0);
    repeat (6) step(0, 0, 1, 1, 2, 0);
    step(0, 0, 0, 1, 2, 0);

    // gaps in up, then up ignored in IDLE
    step(0, 1, 0, 1, 2, 0);
    step(0, 0, 1, 1, 2, 0);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 1, 1, 2, 0);
    step(1, 0, 0, 1, 2, 0);
    step(0, 0, 1, 1, 2, 0);
    step(0, 0, 1, 1, 2, 0);

    // abort at (1,1) of 3x3 together with up, then restart
    step(0, 1, 0, 2, 2, 0);
    repeat (4) step(0, 0, 1, 2, 2, 0);
    step(1, 0, 1, 2, 2, 0);
    step(0, 0, 0, 2, 2, 0);
    step(0, 1, 1, 2, 2, 0);
    repeat (2) step(0, 0, 1, 2, 2, 0);
    step(1, 0, 0, 2, 2, 0);

    // single index
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // one row, bounds 0,3
    step(0, 1, 0, 0, 3, 0);
    repeat (4) step(0, 0, 1, 0, 3, 0);

    // maximum bounds, with input bounds and start churning mid-run
    step(0, 1, 0, 3, 3, 0);
    cnt = 0;
    do begin
      step(0, cnt[0], 1, cnt % 4, (cnt + 1) % 4, cnt[1]);
      cnt++;
    end while (!bus.done && cnt < 100);
    check("max_advances", cnt, 16);

`ifdef INDEX_COUNTER_TRIANGULAR_EN
    // lower triangle of a 3x3, then the same bounds rectangular
    step(0, 1, 0, 2, 3, 1);
    cnt = 0;
    do begin
      step(0, 0, 1, 2, 3, 1);
      cnt++;
    end while (!bus.done && cnt < 100);
    check("tri_advances", cnt, 6);
    step(0, 1, 0, 2, 1, 0);
    repeat (9) step(0, 0, 1, 2, 1, 0);
`endif

    // asynchronous reset mid-run
    step(0, 1, 0, 3, 2, 0);
    repeat (3) step(0, 0, 1, 3, 2, 0);
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compare_all();

    // randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 31) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0),
           int'($urandom_range(0, (1 << RW) - 1)),
           int'($urandom_range(0, (1 << CW) - 1)),
           bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
